// File: rtl/board_write_scheduler.sv
// Write-port scheduler for the 80x60 1-bit whiteboard framebuffer.
// Arbitrates cursor paint writes against a full-board zeroing sweep.
module board_write_scheduler #(
  parameter int COLS = 80,
  parameter int ROWS = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        draw_enable,
  input  logic [6:0]  cursor_x,
  input  logic [5:0]  cursor_y,
  input  logic        pen_black,
  input  logic        clear_req,
  output logic        mem_we,
  output logic [12:0] mem_addr,
  output logic        mem_wdata,
  output logic        clear_busy,
  output logic        clear_done,
  output logic        range_drop
);

  typedef enum logic {IDLE, SWEEP} state_t;

  localparam logic [6:0]  COLS_W    = 7'(COLS);
  localparam logic [5:0]  ROWS_W    = 6'(ROWS);
  localparam logic [12:0] LAST_ADDR = 13'(COLS * ROWS - 1);

  state_t      state, state_next;
  logic [12:0] count, count_next;
  logic [6:0]  last_x;
  logic [5:0]  last_y;
  logic        last_pen;
  logic        pending, pending_next;
  logic        en_q, clr_q;
  logic        exit_q, exit_next;

  logic        change, clr_edge, in_range;
  logic [12:0] paint_addr;
  logic        we_next, wdata_next, busy_next, drop_next;
  logic [12:0] addr_next;

  assign change     = draw_enable &
                      (({cursor_x, cursor_y, pen_black} != {last_x, last_y, last_pen}) | ~en_q);
  assign clr_edge   = clear_req & ~clr_q;
  assign in_range   = (last_x < COLS_W) & (last_y < ROWS_W);
  // y*80 = y*64 + y*16
  assign paint_addr = {1'b0, last_y, 6'b0} + {3'b0, last_y, 4'b0} + {6'b0, last_x};

  always_comb begin
    state_next   = state;
    count_next   = count;
    pending_next = pending;
    exit_next    = 1'b0;
    we_next      = 1'b0;
    addr_next    = 13'd0;
    wdata_next   = 1'b0;
    busy_next    = 1'b0;
    drop_next    = range_drop;
    case (state)
      IDLE: begin
        if (clr_edge) begin
          state_next = SWEEP;
          count_next = 13'd0;
        end else if (pending) begin
          pending_next = 1'b0;
          if (in_range) begin
            we_next    = 1'b1;
            addr_next  = paint_addr;
            wdata_next = last_pen;
          end else begin
            drop_next = 1'b1;
          end
        end
      end
      SWEEP: begin
        busy_next = 1'b1;
        if (clr_edge) begin
          count_next = 13'd0;
        end else begin
          we_next   = 1'b1;
          addr_next = count;
          if (count == LAST_ADDR) begin
            state_next = IDLE;
            count_next = 13'd0;
            exit_next  = 1'b1;
          end else begin
            count_next = count + 13'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // Repaint the cursor cell over the freshly cleared board.
    if (change || (exit_next && draw_enable)) pending_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= 13'd0;
      last_x     <= 7'd0;
      last_y     <= 6'd0;
      last_pen   <= 1'b0;
      pending    <= 1'b0;
      en_q       <= 1'b0;
      clr_q      <= 1'b0;
      exit_q     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 13'd0;
      mem_wdata  <= 1'b0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      range_drop <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      pending    <= pending_next;
      en_q       <= draw_enable;
      clr_q      <= clear_req;
      exit_q     <= exit_next;
      mem_we     <= we_next;
      mem_addr   <= addr_next;
      mem_wdata  <= wdata_next;
      clear_busy <= busy_next;
      clear_done <= exit_q;
      range_drop <= drop_next;
      if (change) begin
        last_x   <= cursor_x;
        last_y   <= cursor_y;
        last_pen <= pen_black;
      end
    end
  end

endmodule

// File: tb/tb_board_write_scheduler.sv
// Directed self-checking bench for board_write_scheduler.
module tb_board_write_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        draw_enable;
  logic [6:0]  cursor_x;
  logic [5:0]  cursor_y;
  logic        pen_black;
  logic        clear_req;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic        mem_wdata;
  logic        clear_busy;
  logic        clear_done;
  logic        range_drop;

  int tests = 0;
  int fails = 0;
  int bad;

  board_write_scheduler #(.COLS(80), .ROWS(60)) dut (
    .clk(clk), .reset(reset), .draw_enable(draw_enable),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .pen_black(pen_black),
    .clear_req(clear_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .clear_busy(clear_busy), .clear_done(clear_done),
    .range_drop(range_drop)
  );

  always #20 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_we"}, 32'(mem_we), 32'd0);
    check({tag, "_busy"}, 32'(clear_busy), 32'd0);
    check({tag, "_done"}, 32'(clear_done), 32'd0);
  endtask

  // One sweep write per cycle, addresses counting from 0.
  task automatic sweep_cycle(input int i);
    step();
    if (mem_we !== 1'b1 || mem_addr !== 13'(i) || mem_wdata !== 1'b0 ||
        clear_busy !== 1'b1 || clear_done !== 1'b0) bad++;
  endtask

  initial begin
    reset = 1'b1; draw_enable = 1'b0; cursor_x = 7'd0; cursor_y = 6'd0;
    pen_black = 1'b0; clear_req = 1'b0;
    step(); step();
    check_quiet("reset");
    check("reset_addr", 32'(mem_addr), 32'd0);
    check("reset_drop", 32'(range_drop), 32'd0);

    // Enable paints current cell (5,3) once.
    reset = 1'b0; draw_enable = 1'b1; cursor_x = 7'd5; cursor_y = 6'd3; pen_black = 1'b1;
    step();
    check("en_lat_we", 32'(mem_we), 32'd0);
    step();
    check("en_we", 32'(mem_we), 32'd1);
    check("en_addr", 32'(mem_addr), 32'd245);
    check("en_wdata", 32'(mem_wdata), 32'd1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (mem_we !== 1'b0) bad++;
    end
    check("hold_nowrite", 32'(bad), 32'd0);

    // Back-to-back steps along row 59.
    cursor_x = 7'd10; cursor_y = 6'd59; pen_black = 1'b0;
    step();
    check("b2b_lat_we", 32'(mem_we), 32'd0);
    cursor_x = 7'd11;
    step();
    check("b2b0_we", 32'(mem_we), 32'd1);
    check("b2b0_addr", 32'(mem_addr), 32'd4730);
    cursor_x = 7'd12;
    step();
    check("b2b1_we", 32'(mem_we), 32'd1);
    check("b2b1_addr", 32'(mem_addr), 32'd4731);
    step();
    check("b2b2_we", 32'(mem_we), 32'd1);
    check("b2b2_addr", 32'(mem_addr), 32'd4732);
    check("b2b2_wdata", 32'(mem_wdata), 32'd0);
    step();
    check("b2b_end_we", 32'(mem_we), 32'd0);

    // Full sweep with a mid-sweep cursor move.
    clear_req = 1'b1;
    step();
    check_quiet("clr_lat");
    bad = 0;
    for (int i = 0; i < 4800; i++) begin
      if (i == 1000) begin
        cursor_x = 7'd20; cursor_y = 6'd10; pen_black = 1'b1;
      end
      sweep_cycle(i);
    end
    check("sweep1_writes", 32'(bad), 32'd0);
    step();
    check("sweep1_done", 32'(clear_done), 32'd1);
    check("sweep1_busy_off", 32'(clear_busy), 32'd0);
    check("repaint_we", 32'(mem_we), 32'd1);
    check("repaint_addr", 32'(mem_addr), 32'd820);
    check("repaint_wdata", 32'(mem_wdata), 32'd1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (mem_we !== 1'b0 || clear_busy !== 1'b0 || clear_done !== 1'b0) bad++;
    end
    check("held_clear_nosweep", 32'(bad), 32'd0);

    // Second sweep, restarted by a fresh clear edge at counter 2000.
    clear_req = 1'b0;
    step();
    clear_req = 1'b1;
    step();
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      sweep_cycle(i);
      if (i == 1998) clear_req = 1'b0;
      if (i == 1999) clear_req = 1'b1;
    end
    check("sweep2_first_part", 32'(bad), 32'd0);
    step();
    check("restart_gap_we", 32'(mem_we), 32'd0);
    check("restart_gap_busy", 32'(clear_busy), 32'd1);
    bad = 0;
    for (int i = 0; i < 4800; i++) sweep_cycle(i);
    check("sweep2_restart", 32'(bad), 32'd0);
    step();
    check("sweep2_done", 32'(clear_done), 32'd1);
    check("sweep2_repaint_addr", 32'(mem_addr), 32'd820);
    step();
    check("sweep2_done_pulse", 32'(clear_done), 32'd0);

    // Reset in the middle of a sweep.
    clear_req = 1'b0;
    step();
    clear_req = 1'b1;
    step();
    bad = 0;
    for (int i = 0; i < 100; i++) sweep_cycle(i);
    check("sweep3_part", 32'(bad), 32'd0);
    reset = 1'b1; clear_req = 1'b0; draw_enable = 1'b0;
    step();
    check_quiet("midreset");
    check("midreset_addr", 32'(mem_addr), 32'd0);
    check("midreset_drop", 32'(range_drop), 32'd0);
    reset = 1'b0;
    step();
    check_quiet("post_reset");

    // Out-of-range paint is dropped and sticks range_drop.
    cursor_x = 7'd90; cursor_y = 6'd0; pen_black = 1'b1; draw_enable = 1'b1;
    step();
    step();
    check("oor_we", 32'(mem_we), 32'd0);
    check("oor_drop", 32'(range_drop), 32'd1);
    cursor_x = 7'd1;
    step();
    step();
    check("after_oor_we", 32'(mem_we), 32'd1);
    check("after_oor_addr", 32'(mem_addr), 32'd1);
    check("drop_sticky", 32'(range_drop), 32'd1);
    step();
    check("drop_sticky2", 32'(range_drop), 32'd1);
    reset = 1'b1;
    step();
    check("drop_reset", 32'(range_drop), 32'd0);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
